// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response channel bundle between memory stage and dmem_responder
interface dmem_responder_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic [WIDTH/8-1:0] req_be;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM with byte lanes and fixed wait states behind valid/ready channels
// Optional misaligned-access error response enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             lat_we;
  logic [AW-1:0]    lat_idx;
  logic [WIDTH-1:0] lat_wdata;
  logic [NB-1:0]    lat_be;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             commit;
  logic             lat_mis;
  logic             unused_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  // Upper address bits alias; only the word index is kept.
  assign unused_addr = ^bus.req_addr;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign commit        = (state == S_WAIT) && (cnt == 4'd0);

`ifdef DMEM_MISALIGN_ERR_EN
  logic rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
  assign lat_mis     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (commit && lat_we && !lat_mis) begin
      for (int i = 0; i < NB; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
      lat_mis     <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_idx   <= bus.req_addr[AW+1:2];
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
`ifdef DMEM_MISALIGN_ERR_EN
            lat_mis   <= |bus.req_addr[1:0];
`endif
            // The accept cycle itself counts, so WAIT lasts WAIT_STATES+1 cycles.
            cnt       <= WS;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            if (!lat_we && !lat_mis) rsp_rdata_q <= mem[lat_idx];
`ifdef DMEM_MISALIGN_ERR_EN
            rsp_err_q   <= lat_mis;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;
  localparam int WS    = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] model [DEPTH];
  bit          written [DEPTH];

  dmem_responder_if #(.WIDTH(32)) bus ();

  dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic bit is_mis(input logic [31:0] addr);
`ifdef DMEM_MISALIGN_ERR_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int k;
    if (is_mis(addr)) return;
    k = widx(addr);
    for (int i = 0; i < 4; i++) if (be[i]) model[k][8*i +: 8] = wdata[8*i +: 8];
    if (be == 4'hF) written[k] = 1'b1;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_before_req got=%b want=1", bus.req_ready); end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_be = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
    total++;
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL req_ready_after_accept got=%b want=0", bus.req_ready); end
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != WS + 1) begin bad++; $display("FAIL latency addr=%h got=%0d want=%0d", addr, lat, WS + 1); end
    held = bus.rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d valid=%b rdata=%h want=%h ready=%b", k, bus.rsp_valid, bus.rsp_rdata, held, bus.req_ready);
      end
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL after_handshake valid=%b rdata=%h err=%b ready=%b want 0/0/0/1", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er); model_store(32'h10, 32'hDEADBEEF, 4'hF);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL store_rsp rdata=%h err=%b want 0/0", rd, er); end
    access(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== model[widx(32'h10)]) begin bad++; $display("FAIL load_0x10 got=%h want=%h", rd, model[widx(32'h10)]); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er;
    access(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er); model_store(32'h20, 32'h11223344, 4'hF);
    access(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, er); model_store(32'h20, 32'hAABBCCDD, 4'h5);
    access(1'b1, 32'h20, 32'h99999999, 4'h0, 0, rd, er);
    access(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== 32'h11BB33DD || rd !== model[widx(32'h20)]) begin bad++; $display("FAIL byte_lanes got=%h want=%h", rd, 32'h11BB33DD); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er;
    access(1'b0, 32'h10, 32'h0, 4'hF, 3, rd, er);
    total++;
    if (rd !== model[widx(32'h10)]) begin bad++; $display("FAIL backpressure_load got=%h want=%h", rd, model[widx(32'h10)]); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic er;
    access(1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 0, rd, er); model_store(32'h004, 32'hCAFEF00D, 4'hF);
    access(1'b0, 32'h404, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_0x404 got=%h want=%h", rd, 32'hCAFEF00D); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er;
    access(1'b1, 32'h30, 32'h12345678, 4'hF, 0, rd, er); model_store(32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hFFFFFFFF; bus.req_be = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk); rst = 1'b1;
    access(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== 32'h12345678) begin bad++; $display("FAIL reset_mid_load got=%h want=%h", rd, 32'h12345678); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er;
    logic [31:0] prior;
    prior = model[widx(32'h20)];
    access(1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, rd, er); model_store(32'h22, 32'hFFFFFFFF, 4'hF);
`ifdef DMEM_MISALIGN_ERR_EN
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_store err=%b rdata=%h want 1/0", er, rd); end
    access(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== prior || er !== 1'b0) begin bad++; $display("FAIL mis_nowrite got=%h err=%b want=%h/0", rd, er, prior); end
    access(1'b0, 32'h21, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL mis_load err=%b rdata=%h want 1/0", er, rd); end
`else
    total++;
    if (er !== 1'b0 || prior === 32'hFFFFFFFF) begin bad++; $display("FAIL noerr_store err=%b want 0", er); end
    access(1'b0, 32'h21, 32'h0, 4'h0, 0, rd, er);
    total++;
    if (rd !== 32'hFFFFFFFF || er !== 1'b0) begin bad++; $display("FAIL low_bits_ignored got=%h err=%b want=ffffffff/0", rd, er); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd; logic er, we; logic [3:0] be; int k;
    for (int n = 0; n < 40; n++) begin
      k    = 64 + int'($urandom_range(0, 7));
      addr = ($urandom & 32'hFFFF_FC00) | (32'(k) << 2);
`ifndef DMEM_MISALIGN_ERR_EN
      addr[1:0] = 2'($urandom);
`endif
      we = $urandom_range(0, 1) == 1 || !written[k];
      wd = $urandom;
      be = written[k] ? 4'($urandom) : 4'hF;
      access(we, addr, wd, be, int'($urandom_range(0, 2)), rd, er);
      total++;
      if (we) begin
        model_store(addr, wd, be);
        if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL rand_store n=%0d rdata=%h err=%b", n, rd, er); end
      end else if (rd !== model[k] || er !== 1'b0) begin
        bad++; $display("FAIL rand_load n=%0d addr=%h got=%h want=%h err=%b", n, addr, rd, model[k], er);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin model[i] = 32'h0; written[i] = 1'b0; end
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_backpressure();
    test_alias();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
